// File: rtl/pipe_hazard_unit.sv
// In-flight result tracker for the execute/memory/writeback pipe: youngest-first operand
// forwarding, load-use stall generation and register-file writeback from the last stage.
module pipe_hazard_unit #(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int NSTAGES             = 2,
    parameter int LD_STAGE            = NSTAGES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ex_valid,
    input  logic                           ex_regWrite,
    input  logic                           ex_isLoad,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_dstReg,
    input  logic [DBITS-1:0]               ex_data,
    input  logic                           flush,
    input  logic                           use1,
    input  logic                           use2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] sr1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] sr2,
    input  logic [DBITS-1:0]               rf1,
    input  logic [DBITS-1:0]               rf2,
    input  logic [DBITS-1:0]               ld_data,
    output logic [DBITS-1:0]               fwd1,
    output logic [DBITS-1:0]               fwd2,
    output logic                           stall,
    output logic                           wb_wrtEn,
    output logic [REG_INDEX_BIT_WIDTH-1:0] wb_dr,
    output logic [DBITS-1:0]               wb_data
);

    logic                           e_valid     [1:NSTAGES];
    logic                           e_reg_write [1:NSTAGES];
    logic [REG_INDEX_BIT_WIDTH-1:0] e_dst       [1:NSTAGES];
    logic [DBITS-1:0]               e_data      [1:NSTAGES];
    logic                           e_ready     [1:NSTAGES];

    logic hazard1;
    logic hazard2;
    logic cap_valid;

    // Scan oldest to youngest so the youngest matching stage overrides older ones.
    function automatic void resolve(
        input  logic [REG_INDEX_BIT_WIDTH-1:0] src,
        input  logic [DBITS-1:0]               rf,
        output logic [DBITS-1:0]               val,
        output logic                           haz
    );
        val = rf;
        haz = 1'b0;
        for (int k = NSTAGES; k >= 1; k--) begin
            if (e_valid[k] && e_reg_write[k] && (e_dst[k] == src)) begin
                if (e_ready[k]) begin
                    val = e_data[k];
                    haz = 1'b0;
                end else if (k < LD_STAGE) begin
                    val = e_data[k];
                    haz = 1'b1;
                end else begin
                    val = ld_data;
                    haz = 1'b0;
                end
            end
        end
    endfunction

    always_comb begin
        fwd1    = rf1;
        fwd2    = rf2;
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        resolve(sr1, rf1, fwd1, hazard1);
        resolve(sr2, rf2, fwd2, hazard2);
    end

    assign stall     = ex_valid & ~flush & ((use1 & hazard1) | (use2 & hazard2));
    assign cap_valid = ex_valid & ~flush & ~stall;

    always_comb begin
        wb_wrtEn = e_valid[NSTAGES] & e_reg_write[NSTAGES];
        wb_dr    = '0;
        wb_data  = '0;
        if (wb_wrtEn) begin
            wb_dr   = e_dst[NSTAGES];
            wb_data = e_ready[NSTAGES] ? e_data[NSTAGES] : ld_data;
        end
    end

    // The pipe never holds: a stall only turns the incoming slot into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= NSTAGES; k++) begin
                e_valid[k]     <= 1'b0;
                e_reg_write[k] <= 1'b0;
                e_dst[k]       <= '0;
                e_data[k]      <= '0;
                e_ready[k]     <= 1'b1;
            end
        end else begin
            e_valid[1]     <= cap_valid;
            e_reg_write[1] <= cap_valid & ex_regWrite;
            e_dst[1]       <= ex_dstReg;
            e_data[1]      <= ex_data;
            e_ready[1]     <= ~ex_isLoad;
            for (int k = 1; k < NSTAGES; k++) begin
                e_valid[k+1]     <= e_valid[k];
                e_reg_write[k+1] <= e_reg_write[k];
                e_dst[k+1]       <= e_dst[k];
                if ((k == LD_STAGE) && !e_ready[k]) begin
                    e_data[k+1]  <= ld_data;
                    e_ready[k+1] <= 1'b1;
                end else begin
                    e_data[k+1]  <= e_data[k];
                    e_ready[k+1] <= e_ready[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: a 2-stage instance (a) and a 3-stage instance with
// load data at stage 2 (b) share one stimulus stream; expected values are hand-derived.
module tb_pipe_hazard_unit;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_regWrite;
    logic        ex_isLoad;
    logic [3:0]  ex_dstReg;
    logic [31:0] ex_data;
    logic        flush;
    logic        use1;
    logic        use2;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [31:0] ld_data;

    logic [31:0] fwd1_a, fwd2_a, wb_data_a;
    logic        stall_a, wb_wrtEn_a;
    logic [3:0]  wb_dr_a;
    logic [31:0] fwd1_b, fwd2_b, wb_data_b;
    logic        stall_b, wb_wrtEn_b;
    logic [3:0]  wb_dr_b;

    int checks = 0;
    int errors = 0;

    pipe_hazard_unit #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .NSTAGES(2), .LD_STAGE(2)) dut_a (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_regWrite(ex_regWrite),
        .ex_isLoad(ex_isLoad), .ex_dstReg(ex_dstReg), .ex_data(ex_data), .flush(flush),
        .use1(use1), .use2(use2), .sr1(sr1), .sr2(sr2), .rf1(rf1), .rf2(rf2),
        .ld_data(ld_data), .fwd1(fwd1_a), .fwd2(fwd2_a), .stall(stall_a),
        .wb_wrtEn(wb_wrtEn_a), .wb_dr(wb_dr_a), .wb_data(wb_data_a)
    );

    pipe_hazard_unit #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .NSTAGES(3), .LD_STAGE(2)) dut_b (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_regWrite(ex_regWrite),
        .ex_isLoad(ex_isLoad), .ex_dstReg(ex_dstReg), .ex_data(ex_data), .flush(flush),
        .use1(use1), .use2(use2), .sr1(sr1), .sr2(sr2), .rf1(rf1), .rf2(rf2),
        .ld_data(ld_data), .fwd1(fwd1_b), .fwd2(fwd2_b), .stall(stall_b),
        .wb_wrtEn(wb_wrtEn_b), .wb_dr(wb_dr_b), .wb_data(wb_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic ld,
                                 input logic [3:0] dst, input logic [31:0] data,
                                 input logic fl);
        ex_valid    = v;
        ex_regWrite = rw;
        ex_isLoad   = ld;
        ex_dstReg   = dst;
        ex_data     = data;
        flush       = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        use1 = 1'b1; use2 = 1'b1; sr1 = 4'd3; sr2 = 4'd3;
        rf1 = 32'h11; rf2 = 32'h22; ld_data = 32'h0;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 32'h99, 1'b0);

        // Reset with a live execute instruction
        tick();
        checkOutput("rst_wb_wrtEn_a", {31'b0, wb_wrtEn_a}, 32'd0);
        checkOutput("rst_stall_a", {31'b0, stall_a}, 32'd0);
        checkOutput("rst_fwd1_a", fwd1_a, 32'h11);
        checkOutput("rst_fwd2_a", fwd2_a, 32'h22);
        checkOutput("rst_wb_dr_a", {28'b0, wb_dr_a}, 32'd0);
        checkOutput("rst_wb_data_a", wb_data_a, 32'd0);
        checkOutput("rst_wb_wrtEn_b", {31'b0, wb_wrtEn_b}, 32'd0);
        checkOutput("rst_fwd1_b", fwd1_b, 32'h11);
        reset = 1'b0;
        use1 = 1'b0; use2 = 1'b0;

        // ALU chain r3 <= 5
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 32'h5, 1'b0);
        tick();
        use1 = 1'b1; sr1 = 4'd3;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        checkOutput("alu_fwd1_a", fwd1_a, 32'h5);
        checkOutput("alu_stall_a", {31'b0, stall_a}, 32'd0);
        checkOutput("alu_wb_early_a", {31'b0, wb_wrtEn_a}, 32'd0);
        tick();
        checkOutput("alu_wb_wrtEn_a", {31'b0, wb_wrtEn_a}, 32'd1);
        checkOutput("alu_wb_dr_a", {28'b0, wb_dr_a}, 32'd3);
        checkOutput("alu_wb_data_a", wb_data_a, 32'h5);
        checkOutput("alu_fwd1_e2_a", fwd1_a, 32'h5);
        checkOutput("alu_wb_early_b", {31'b0, wb_wrtEn_b}, 32'd0);
        tick();
        checkOutput("alu_wb_dr_b", {28'b0, wb_dr_b}, 32'd3);
        checkOutput("alu_wb_data_b", wb_data_b, 32'h5);
        checkOutput("alu_drained_fwd1_a", fwd1_a, 32'h11);

        // Youngest of two writers to r2 wins
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 32'hA, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 32'hB, 1'b0);
        tick();
        sr1 = 4'd2; sr2 = 4'd2; use1 = 1'b1; use2 = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        checkOutput("prio_fwd1_a", fwd1_a, 32'hB);
        checkOutput("prio_fwd2_a", fwd2_a, 32'hB);
        checkOutput("prio_wb_data_a", wb_data_a, 32'hA);
        tick();
        checkOutput("prio_late_fwd1_a", fwd1_a, 32'hB);
        checkOutput("prio_late_wb_a", wb_data_a, 32'hB);
        checkOutput("prio_late_fwd1_b", fwd1_b, 32'hB);
        tick();
        checkOutput("prio_drained_fwd1_a", fwd1_a, 32'h11);

        // Reset in the middle of traffic
        sr1 = 4'd1;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd1, 32'h1, 1'b0);
        tick();
        tick();
        checkOutput("mid_pre_wb_dr_a", {28'b0, wb_dr_a}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        checkOutput("mid_wb_wrtEn_a", {31'b0, wb_wrtEn_a}, 32'd0);
        checkOutput("mid_wb_wrtEn_b", {31'b0, wb_wrtEn_b}, 32'd0);
        checkOutput("mid_fwd1_a", fwd1_a, 32'h11);

        // Load-use: load r4 then consume it
        use1 = 1'b0; use2 = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, 32'h1234, 1'b0);
        tick();
        use1 = 1'b1; sr1 = 4'd4;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd6, 32'h66, 1'b0);
        checkOutput("lu_stall_b", {31'b0, stall_b}, 32'd1);
        checkOutput("lu_stall_a", {31'b0, stall_a}, 32'd1);
        tick();
        ld_data = 32'hDEAD;
        #1;
        checkOutput("lu_release_stall_b", {31'b0, stall_b}, 32'd0);
        checkOutput("lu_fwd1_b", fwd1_b, 32'hDEAD);
        tick();
        ld_data = 32'hBEEF;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        checkOutput("lu_wb_dr_b", {28'b0, wb_dr_b}, 32'd4);
        checkOutput("lu_wb_data_b", wb_data_b, 32'hDEAD);
        checkOutput("lu_fwd1_e3_b", fwd1_b, 32'hDEAD);
        tick();
        checkOutput("lu_bubble_wb_b", {31'b0, wb_wrtEn_b}, 32'd0);
        tick();
        checkOutput("lu_consumer_wb_dr_b", {28'b0, wb_dr_b}, 32'd6);
        checkOutput("lu_consumer_wb_data_b", wb_data_b, 32'h66);

        // Unused source and flush override
        reset = 1'b1;
        tick();
        reset = 1'b0;
        use1 = 1'b0; use2 = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, 32'h0, 1'b0);
        tick();
        sr1 = 4'd0; sr2 = 4'd4;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd8, 32'h88, 1'b0);
        checkOutput("unused_stall_b", {31'b0, stall_b}, 32'd0);
        use2 = 1'b1;
        #1;
        checkOutput("used2_stall_b", {31'b0, stall_b}, 32'd1);
        flush = 1'b1;
        #1;
        checkOutput("flush_over_stall_b", {31'b0, stall_b}, 32'd0);

        // Flushed writer of r5 never reaches writeback
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rf1 = 32'h77; ld_data = 32'hDEAD;
        use1 = 1'b0; use2 = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 32'h0, 1'b0);
        tick();
        use1 = 1'b1; sr1 = 4'd7;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 32'h55, 1'b1);
        checkOutput("fl_stall_b", {31'b0, stall_b}, 32'd0);
        tick();
        sr1 = 4'd5;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        checkOutput("fl_fwd1_e1_b", fwd1_b, 32'h77);
        tick();
        checkOutput("fl_load_wb_dr_b", {28'b0, wb_dr_b}, 32'd7);
        checkOutput("fl_load_wb_data_b", wb_data_b, 32'hDEAD);
        checkOutput("fl_fwd1_e2_b", fwd1_b, 32'h77);
        tick();
        checkOutput("fl_slot_wb_wrtEn_b", {31'b0, wb_wrtEn_b}, 32'd0);
        checkOutput("fl_fwd1_e3_b", fwd1_b, 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
